// File: rtl/oric_tap_loader_if.sv
// Bus bundle between data_io's download channel, the TAP loader and SDRAM port2.
// The master modport is the loader's view; slave is the surrounding system.
interface oric_tap_loader_if;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic        port_req;
   logic        port_ack;
   logic [15:0] port_a;
   logic [1:0]  port_ds;
   logic        port_we;
   logic [15:0] port_d;

   modport master (
      input  ioctl_download, ioctl_wr, ioctl_dout, port_ack,
      output ioctl_wait, port_req, port_a, port_ds, port_we, port_d
   );

   modport slave (
      output ioctl_download, ioctl_wr, ioctl_dout, port_ack,
      input  ioctl_wait, port_req, port_a, port_ds, port_we, port_d
   );
endinterface

// File: rtl/oric_tap_loader.sv
// Oric .TAP loader: parses the tape header from the download stream and writes the
// payload into SDRAM port2 through a small byte FIFO using the toggle req/ack handshake.
module oric_tap_loader #(
   parameter int FIFO_DEPTH = 4,
   parameter int NAME_MAX   = 16
) (
   input  logic              clk,
   input  logic              reset,
   oric_tap_loader_if.master bus,
   output logic [15:0]       start_addr,
   output logic [15:0]       end_addr,
   output logic              autorun,
   output logic              is_basic,
   output logic              done,
   output logic              error
);
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = PTR_W + 1;
   localparam int NAME_W = $clog2(NAME_MAX + 1);

   typedef enum logic [3:0] {
      ST_IDLE, ST_SYNC, ST_MARKER, ST_HEADER, ST_NAME,
      ST_DATA, ST_FLUSH, ST_DONE, ST_ERROR
   } state_t;

   state_t            state_r, state_nx_s;
   logic              dl_prev_r;
   logic              dl_rise_s, dl_fall_s;
   logic              clear_s, push_s, pop_s, ack_idle_s, fifo_full_s, hdr_bad_s;
   logic [CNT_W-1:0]  fifo_cnt_r, fifo_cnt_nx_s;
   logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
   logic [7:0]        fifo_mem_r [FIFO_DEPTH];
   logic [7:0]        pop_byte_s;
   logic [1:0]        sync_cnt_r;
   logic [3:0]        hdr_idx_r;
   logic [NAME_W-1:0] name_cnt_r;
   logic [16:0]       remaining_r;
   logic [15:0]       wr_addr_r;
   logic [15:0]       start_addr_r, end_addr_r;
   logic              autorun_r, is_basic_r, done_r, error_r, wait_r;
   logic              port_req_r, port_we_r;
   logic [15:0]       port_a_r, port_d_r;
   logic [1:0]        port_ds_r;

   assign dl_rise_s   = bus.ioctl_download & ~dl_prev_r;
   assign dl_fall_s   = ~bus.ioctl_download & dl_prev_r;
   assign clear_s     = dl_rise_s;
   assign ack_idle_s  = (port_req_r == bus.port_ack);
   assign fifo_full_s = (fifo_cnt_r == CNT_W'(FIFO_DEPTH));
   assign hdr_bad_s   = (end_addr_r < start_addr_r) || (end_addr_r >= 16'hC000);
   assign pop_byte_s  = fifo_mem_r[rd_ptr_r];
   // The writer drains independently of the parser, but freezes once an error is latched.
   assign pop_s       = (fifo_cnt_r != {CNT_W{1'b0}}) && ack_idle_s &&
                        (state_r != ST_ERROR) && !clear_s;

   // Parser next-state and FIFO push decision.
   always_comb begin
      state_nx_s = state_r;
      push_s     = 1'b0;
      if (dl_rise_s) begin
         state_nx_s = ST_SYNC;
      end else if (dl_fall_s && (state_r inside {ST_SYNC, ST_MARKER, ST_HEADER, ST_NAME, ST_DATA})) begin
         state_nx_s = ST_ERROR;
      end else begin
         case (state_r)
            ST_SYNC: begin
               if (bus.ioctl_wr) begin
                  if (bus.ioctl_dout != 8'h16)  state_nx_s = ST_ERROR;
                  else if (sync_cnt_r == 2'd2)  state_nx_s = ST_MARKER;
                  else                          state_nx_s = ST_SYNC;
               end else begin
                  state_nx_s = ST_SYNC;
               end
            end
            ST_MARKER: begin
               if (bus.ioctl_wr) begin
                  if (bus.ioctl_dout == 8'h24)       state_nx_s = ST_HEADER;
                  else if (bus.ioctl_dout == 8'h16)  state_nx_s = ST_MARKER;
                  else                               state_nx_s = ST_ERROR;
               end else begin
                  state_nx_s = ST_MARKER;
               end
            end
            ST_HEADER: begin
               if (bus.ioctl_wr && (hdr_idx_r == 4'd8)) begin
                  if (hdr_bad_s) state_nx_s = ST_ERROR;
                  else           state_nx_s = ST_NAME;
               end else begin
                  state_nx_s = ST_HEADER;
               end
            end
            ST_NAME: begin
               if (bus.ioctl_wr) begin
                  if (bus.ioctl_dout == 8'h00)                 state_nx_s = ST_DATA;
                  else if (name_cnt_r == NAME_W'(NAME_MAX))    state_nx_s = ST_ERROR;
                  else                                         state_nx_s = ST_NAME;
               end else begin
                  state_nx_s = ST_NAME;
               end
            end
            ST_DATA: begin
               if (bus.ioctl_wr) begin
                  if (fifo_full_s) begin
                     state_nx_s = ST_ERROR;
                  end else begin
                     push_s = 1'b1;
                     if (remaining_r == 17'd1) state_nx_s = ST_FLUSH;
                     else                      state_nx_s = ST_DATA;
                  end
               end else begin
                  state_nx_s = ST_DATA;
               end
            end
            ST_FLUSH: begin
               if ((fifo_cnt_r == {CNT_W{1'b0}}) && ack_idle_s) state_nx_s = ST_DONE;
               else                                             state_nx_s = ST_FLUSH;
            end
            ST_IDLE, ST_DONE, ST_ERROR: state_nx_s = state_r;
            default: state_nx_s = ST_IDLE;
         endcase
      end
   end

   // FIFO occupancy for the next cycle.
   always_comb begin
      fifo_cnt_nx_s = fifo_cnt_r;
      if (clear_s)                fifo_cnt_nx_s = {CNT_W{1'b0}};
      else if (push_s && !pop_s)  fifo_cnt_nx_s = fifo_cnt_r + CNT_W'(1);
      else if (!push_s && pop_s)  fifo_cnt_nx_s = fifo_cnt_r - CNT_W'(1);
      else                        fifo_cnt_nx_s = fifo_cnt_r;
   end

   // Parser state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_r <= ST_IDLE;
      else       state_r <= state_nx_s;
   end

   // Header capture, parse counters and status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dl_prev_r    <= 1'b0;
         sync_cnt_r   <= 2'd0;
         hdr_idx_r    <= 4'd0;
         name_cnt_r   <= {NAME_W{1'b0}};
         remaining_r  <= 17'd0;
         start_addr_r <= 16'h0000;
         end_addr_r   <= 16'h0000;
         autorun_r    <= 1'b0;
         is_basic_r   <= 1'b0;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
      end else begin
         dl_prev_r <= bus.ioctl_download;
         if (clear_s) begin
            sync_cnt_r  <= 2'd0;
            hdr_idx_r   <= 4'd0;
            name_cnt_r  <= {NAME_W{1'b0}};
            remaining_r <= 17'd0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
         end else begin
            if (bus.ioctl_wr && (state_r == ST_SYNC) && (bus.ioctl_dout == 8'h16))
               sync_cnt_r <= sync_cnt_r + 2'd1;
            if (bus.ioctl_wr && (state_r == ST_HEADER)) begin
               hdr_idx_r <= hdr_idx_r + 4'd1;
               case (hdr_idx_r)
                  4'd2:    is_basic_r        <= (bus.ioctl_dout == 8'h00);
                  4'd3:    autorun_r         <= (bus.ioctl_dout != 8'h00);
                  4'd4:    end_addr_r[15:8]   <= bus.ioctl_dout;
                  4'd5:    end_addr_r[7:0]    <= bus.ioctl_dout;
                  4'd6:    start_addr_r[15:8] <= bus.ioctl_dout;
                  4'd7:    start_addr_r[7:0]  <= bus.ioctl_dout;
                  default: ;
               endcase
            end
            if (bus.ioctl_wr && (state_r == ST_NAME) && (bus.ioctl_dout != 8'h00))
               name_cnt_r <= name_cnt_r + NAME_W'(1);
            if ((state_r == ST_HEADER) && (state_nx_s == ST_NAME))
               remaining_r <= {1'b0, end_addr_r} - {1'b0, start_addr_r} + 17'd1;
            else if (push_s)
               remaining_r <= remaining_r - 17'd1;
            if ((state_r == ST_FLUSH) && (state_nx_s == ST_DONE))
               done_r <= 1'b1;
            if ((state_nx_s == ST_ERROR) && (state_r != ST_ERROR))
               error_r <= 1'b1;
         end
      end
   end

   // FIFO pointers, occupancy and backpressure.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_r   <= {PTR_W{1'b0}};
         rd_ptr_r   <= {PTR_W{1'b0}};
         fifo_cnt_r <= {CNT_W{1'b0}};
         wait_r     <= 1'b0;
      end else begin
         fifo_cnt_r <= fifo_cnt_nx_s;
         wait_r     <= (fifo_cnt_nx_s >= CNT_W'(FIFO_DEPTH - 1));
         if (clear_s) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
         end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
      end
   end

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (push_s) fifo_mem_r[wr_ptr_r] <= bus.ioctl_dout;
   end

   // SDRAM port2 writer: one toggle per popped byte, held until the ack matches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         port_req_r <= 1'b0;
         port_we_r  <= 1'b0;
         port_a_r   <= 16'h0000;
         port_d_r   <= 16'h0000;
         port_ds_r  <= 2'b01;
         wr_addr_r  <= 16'h0000;
      end else begin
         if (pop_s) begin
            port_req_r <= ~port_req_r;
            port_we_r  <= 1'b1;
            port_a_r   <= wr_addr_r;
            port_d_r   <= {pop_byte_s, pop_byte_s};
            port_ds_r  <= wr_addr_r[0] ? 2'b10 : 2'b01;
         end else if (ack_idle_s) begin
            port_we_r  <= 1'b0;
         end
         if ((state_r == ST_HEADER) && (state_nx_s == ST_NAME))
            wr_addr_r <= start_addr_r;
         else if (pop_s)
            wr_addr_r <= wr_addr_r + 16'd1;
      end
   end

   assign bus.ioctl_wait = wait_r;
   assign bus.port_req   = port_req_r;
   assign bus.port_we    = port_we_r;
   assign bus.port_a     = port_a_r;
   assign bus.port_d     = port_d_r;
   assign bus.port_ds    = port_ds_r;
   assign start_addr     = start_addr_r;
   assign end_addr       = end_addr_r;
   assign autorun        = autorun_r;
   assign is_basic       = is_basic_r;
   assign done           = done_r;
   assign error          = error_r;
endmodule

// File: tb/tb_oric_tap_loader.sv
// Scoreboard bench for oric_tap_loader: directed TAP files, expected SDRAM writes queued
// by the stimulus and matched by a monitor on each port_req toggle.
`timescale 1ns/1ps
module tb_oric_tap_loader;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] start_addr, end_addr;
   logic        autorun, is_basic, done, error;

   oric_tap_loader_if bus ();

   oric_tap_loader #(.FIFO_DEPTH(4), .NAME_MAX(16)) dut (
      .clk        (clk),
      .reset      (rst),
      .bus        (bus),
      .start_addr (start_addr),
      .end_addr   (end_addr),
      .autorun    (autorun),
      .is_basic   (is_basic),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] a;
      logic [1:0]  ds;
      logic [15:0] d;
   } wr_t;

   wr_t exp_q [$];
   int  n_checks     = 0;
   int  n_fail       = 0;
   int  write_cnt    = 0;
   int  ack_delay    = 0;
   int  ack_cnt      = 0;
   int  strobe_cnt   = 0;
   int  seen_wait_at = -1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   // SDRAM port2 model: answers a toggled request after ack_delay extra cycles.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.port_ack <= 1'b0;
         ack_cnt      <= 0;
      end else if (bus.port_req != bus.port_ack) begin
         if (ack_cnt >= ack_delay) begin
            bus.port_ack <= bus.port_req;
            ack_cnt      <= 0;
         end else begin
            ack_cnt <= ack_cnt + 1;
         end
      end
   end

   initial begin : monitor
      logic prev_req;
      wr_t  e;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_req = 1'b0;
         end else if (bus.port_req !== prev_req) begin
            prev_req = bus.port_req;
            write_cnt++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_write: got write to %0h, required none", bus.port_a);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 32'(bus.port_a), 32'(e.a));
               check("wr_ds",   32'(bus.port_ds), 32'(e.ds));
               check("wr_data", 32'(bus.port_d), 32'(e.d));
               check("wr_we",   32'(bus.port_we), 32'd1);
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int guard;
      guard = 0;
      @(negedge clk);
      while (bus.ioctl_wait && (guard < 500)) begin
         if (seen_wait_at < 0) seen_wait_at = strobe_cnt;
         guard++;
         @(negedge clk);
      end
      if (guard >= 500) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_timeout: ioctl_wait stuck at 1, required release");
      end
      bus.ioctl_dout = b;
      bus.ioctl_wr   = 1'b1;
      strobe_cnt++;
      @(negedge clk);
      bus.ioctl_wr   = 1'b0;
   endtask

   task automatic send_data(input logic [7:0] b, input logic [15:0] a, input bit expect_wr);
      wr_t w;
      if (expect_wr) begin
         w.a  = a;
         w.ds = a[0] ? 2'b10 : 2'b01;
         w.d  = {b, b};
         exp_q.push_back(w);
      end
      send_byte(b);
   endtask

   task automatic begin_file(input string nm);
      @(negedge clk);
      bus.ioctl_download = 1'b1;
      repeat (2) @(negedge clk);
      check({nm, "_done_clr"},  32'(done),  32'd0);
      check({nm, "_error_clr"}, 32'(error), 32'd0);
   endtask

   task automatic end_file();
      @(negedge clk);
      bus.ioctl_download = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_sync(input int n);
      for (int i = 0; i < n; i++) send_byte(8'h16);
      send_byte(8'h24);
   endtask

   task automatic send_header(input logic [7:0] typ, input logic [7:0] aut,
                              input logic [15:0] e, input logic [15:0] s);
      send_byte(8'h00); send_byte(8'h00); send_byte(typ); send_byte(aut);
      send_byte(e[15:8]); send_byte(e[7:0]); send_byte(s[15:8]); send_byte(s[7:0]);
      send_byte(8'h00);
   endtask

   task automatic wait_status(input string nm, input int max_cycles);
      int n;
      n = 0;
      while (!(done || error) && (n < max_cycles)) begin
         @(negedge clk);
         n++;
      end
      if (n >= max_cycles) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: done/error still 0 after %0d cycles, required 1", nm, n);
      end
   endtask

   task automatic wait_drain(input string nm, input int max_cycles);
      int n;
      n = 0;
      while (((exp_q.size() != 0) || (bus.port_req !== bus.port_ack)) && (n < max_cycles)) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      check({nm, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset_state(input string nm);
      check({nm, "_port_req"}, 32'(bus.port_req), 32'd0);
      check({nm, "_port_a"},   32'(bus.port_a), 32'd0);
      check({nm, "_port_d"},   32'(bus.port_d), 32'd0);
      check({nm, "_port_ds"},  32'(bus.port_ds), 32'd1);
      check({nm, "_port_we"},  32'(bus.port_we), 32'd0);
      check({nm, "_start"},    32'(start_addr), 32'd0);
      check({nm, "_end"},      32'(end_addr), 32'd0);
      check({nm, "_flags"},    32'({autorun, is_basic, done, error, bus.ioctl_wait}), 32'd0);
   endtask

   task automatic run_valid_file(input string nm);
      int w0;
      w0 = write_cnt;
      begin_file(nm);
      send_sync(4);
      send_header(8'h80, 8'hC7, 16'h0500, 16'h0500);
      send_byte(8'h41);
      send_byte(8'h00);
      send_data(8'hAA, 16'h0500, 1'b1);
      wait_status(nm, 200);
      wait_drain(nm, 200);
      check({nm, "_done"},     32'(done), 32'd1);
      check({nm, "_error"},    32'(error), 32'd0);
      check({nm, "_start"},    32'(start_addr), 32'h0500);
      check({nm, "_end"},      32'(end_addr), 32'h0500);
      check({nm, "_autorun"},  32'(autorun), 32'd1);
      check({nm, "_is_basic"}, 32'(is_basic), 32'd0);
      check({nm, "_writes"},   32'(write_cnt - w0), 32'd1);
      end_file();
   endtask

   initial begin : stimulus
      int w0;
      bus.ioctl_download = 1'b0;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_dout     = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_valid_file("valid");

      // Slow ack, eight bytes from an odd address.
      ack_delay = 20;
      w0 = write_cnt;
      begin_file("slow");
      send_sync(3);
      send_header(8'h00, 8'h00, 16'h1008, 16'h1001);
      send_byte(8'h58);
      send_byte(8'h00);
      strobe_cnt   = 0;
      seen_wait_at = -1;
      for (int i = 0; i < 8; i++)
         send_data(8'(8'h11 * (i + 1)), 16'h1001 + 16'(i), 1'b1);
      wait_status("slow", 2000);
      wait_drain("slow", 200);
      check("slow_wait_at", 32'(seen_wait_at), 32'd4);
      check("slow_done", 32'(done), 32'd1);
      check("slow_error", 32'(error), 32'd0);
      check("slow_is_basic", 32'(is_basic), 32'd1);
      check("slow_autorun", 32'(autorun), 32'd0);
      check("slow_start", 32'(start_addr), 32'h1001);
      check("slow_end", 32'(end_addr), 32'h1008);
      check("slow_writes", 32'(write_cnt - w0), 32'd8);
      ack_delay = 0;
      end_file();

      // Marker after only two sync bytes.
      w0 = write_cnt;
      begin_file("badsync");
      send_byte(8'h16);
      send_byte(8'h16);
      send_byte(8'h24);
      repeat (4) @(negedge clk);
      check("badsync_error", 32'(error), 32'd1);
      check("badsync_done", 32'(done), 32'd0);
      check("badsync_writes", 32'(write_cnt - w0), 32'd0);
      end_file();

      // end below start.
      w0 = write_cnt;
      begin_file("endlow");
      send_sync(4);
      send_header(8'h00, 8'h00, 16'h0400, 16'h0500);
      repeat (3) @(negedge clk);
      check("endlow_error", 32'(error), 32'd1);
      check("endlow_end", 32'(end_addr), 32'h0400);
      check("endlow_writes", 32'(write_cnt - w0), 32'd0);
      end_file();

      // end in ROM area.
      begin_file("endrom");
      send_sync(4);
      send_header(8'h00, 8'h00, 16'hC000, 16'h8000);
      repeat (3) @(negedge clk);
      check("endrom_error", 32'(error), 32'd1);
      end_file();

      // Download drops after 3 of 10 payload bytes.
      w0 = write_cnt;
      begin_file("drop");
      send_sync(5);
      send_header(8'h00, 8'h01, 16'h3009, 16'h3000);
      send_byte(8'h00);
      send_data(8'h01, 16'h3000, 1'b1);
      send_data(8'h02, 16'h3001, 1'b1);
      send_data(8'h03, 16'h3002, 1'b1);
      wait_drain("drop", 100);
      check("drop_error_before", 32'(error), 32'd0);
      end_file();
      check("drop_error", 32'(error), 32'd1);
      check("drop_done", 32'(done), 32'd0);
      check("drop_writes", 32'(write_cnt - w0), 32'd3);

      // Trailing bytes after a complete payload.
      w0 = write_cnt;
      begin_file("trail");
      send_sync(4);
      send_header(8'h00, 8'h00, 16'h4001, 16'h4000);
      send_byte(8'h5A);
      send_byte(8'h00);
      send_data(8'h5A, 16'h4000, 1'b1);
      send_data(8'hA5, 16'h4001, 1'b1);
      send_data(8'hEE, 16'h4002, 1'b0);
      send_data(8'hEF, 16'h4003, 1'b0);
      send_data(8'hF0, 16'h4004, 1'b0);
      wait_status("trail", 200);
      wait_drain("trail", 200);
      check("trail_done", 32'(done), 32'd1);
      check("trail_error", 32'(error), 32'd0);
      check("trail_writes", 32'(write_cnt - w0), 32'd2);
      end_file();

      // Reset while in DATA.
      begin_file("rstdata");
      send_sync(4);
      send_header(8'h00, 8'h01, 16'h2003, 16'h2000);
      send_byte(8'h00);
      send_data(8'h10, 16'h2000, 1'b1);
      send_data(8'h20, 16'h2001, 1'b1);
      send_data(8'h30, 16'h2002, 1'b1);
      wait_drain("rstdata", 100);
      check("rstdata_req_before", 32'(bus.port_req), 32'd1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      bus.ioctl_download = 1'b0;
      @(negedge clk);
      check_reset_state("rstdata");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      run_valid_file("after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/oric_tap_loader.md
# oric_tap_loader

Streams an Oric `.TAP` image from the `data_io` download channel into Oric RAM held in SDRAM, through the SDRAM controller's currently idle second port (port2). The block parses the tape header (sync, marker, 9-byte header, filename) and captures start address, end address, type and autorun. It then writes each payload byte to its target address using the controller's toggle req/ack handshake. A 4-entry byte FIFO decouples the download strobes from SDRAM latency. The block sits between `data_io` (upstream) and port2 of `sdram` (downstream), in the 72 MHz SDRAM clock domain.

## Interface
- `FIFO_DEPTH`, 4: payload byte FIFO entries (power of two, ≥2).
- `NAME_MAX`, 16: maximum filename characters before the terminating 0x00.
- `clk` in 1: SDRAM clock (clk_72); all logic on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `ioctl_download` in 1: high for the whole file transfer; synchronous to `clk`.
- `ioctl_wr` in 1: one-cycle strobe, `ioctl_dout` valid.
- `ioctl_dout` in 8: file byte.
- `ioctl_wait` out 1: backpressure; source issues no `ioctl_wr` in the cycle after it is seen high.
- `port_req` out 1: toggle request to sdram port2.
- `port_ack` in 1: toggle acknowledge; equals `port_req` when idle.
- `port_a` out 16: byte address.
- `port_ds` out 2: byte lane select; 2'b10 if `port_a[0]`, else 2'b01.
- `port_we` out 1: always 1 while a request is outstanding.
- `port_d` out 16: `{byte, byte}`.
- `start_addr` out 16: captured header start address.
- `end_addr` out 16: captured header end address.
- `autorun` out 1: header autorun byte != 0.
- `is_basic` out 1: header type byte == 0x00.
- `done` out 1: level; high after the final payload write is acknowledged.
- `error` out 1: sticky until the next rising edge of `ioctl_download`.

## Operation
- States: IDLE, SYNC, MARKER, HEADER, NAME, DATA, FLUSH, DONE, ERROR.
- IDLE: a rising edge of `ioctl_download` clears `done`, `error`, counters and the FIFO, then goes to SYNC.
- SYNC: counts 0x16 bytes. After ≥3 of them, byte 0x24 goes to HEADER. Byte 0x24 with a count below 3, or any byte other than 0x16/0x24, goes to ERROR.
- HEADER: 9 bytes, index h0..h8.
  - h2 gives type; h3 gives autorun.
  - end = {h4,h5}; start = {h6,h7}.
  - h0, h1, h8 are ignored.
  - After h8: end < start or end ≥ 0xC000 (ROM area) goes to ERROR; otherwise go to NAME.
- NAME: bytes are discarded until 0x00, then go to DATA. A (NAME_MAX+1)th non-zero byte goes to ERROR.
- DATA: each byte is pushed to the FIFO. `remaining` = end−start+1 (17-bit) and decrements per push. At 0 go to FLUSH. Bytes after that are ignored, and no error is raised.
- Writer (independent of the parser):
  - When the FIFO is non-empty and `port_req == port_ack`, pop one byte.
  - Drive `port_a` = wr_addr, `port_d`, `port_ds`; toggle `port_req`.
  - Increment wr_addr, which was initialised to start at the end of HEADER.
  - Outputs stay stable until `port_ack` equals `port_req`.
- FLUSH: FIFO empty and `port_req == port_ack` goes to DONE and sets `done`.
- `ioctl_download` falling in SYNC..DATA goes to ERROR. A falling edge in FLUSH is legal.
- ERROR/DONE: stay until the next rising edge of `ioctl_download`. A write already outstanding still completes, but no new pops occur in ERROR.
- FIFO: `ioctl_wait` = count ≥ FIFO_DEPTH−1. A push when count == FIFO_DEPTH drops the byte and goes to ERROR. Simultaneous push and pop keeps count unchanged.

## Timing
- Reset values:
  - `port_req`=0, `port_a`=0, `port_d`=0, `port_ds`=2'b01, `port_we`=0.
  - `start_addr`=0, `end_addr`=0, `autorun`=0, `is_basic`=0, `done`=0, `error`=0, `ioctl_wait`=0.
  - State IDLE.
- Push occurs in the cycle after the `ioctl_wr` edge. The earliest `port_req` toggle is 1 cycle after the push (2 cycles after strobe when idle).
- Back-to-back writes: the next toggle comes 1 cycle after the ack match is seen.
- `done` rises 1 cycle after the last ack match.
- Header outputs update in the cycle after the corresponding byte strobe.
- `reset` mid-transfer aborts immediately. A toggle already issued to sdram is not recalled; port_req returns to 0 and the team's integration resets sdram together.

## Test plan
- Valid file: 0x16×4, 0x24, header {00,00,80,C7,05,00,05,00}+00 (end 0x0500, start 0x0500), name "A",00, payload 0xAA. Required: one write to 0x0500, ds=01, d=0xAAAA; start/end=0x0500; autorun=1; is_basic=0; done=1.
- Slow ack (ack delayed 20 cycles), 8-byte payload at 0x1001: `ioctl_wait` asserts at count 3, no byte is lost, and addresses 0x1001..0x1008 are written in order with alternating ds 10/01.
- Bad sync: 0x16, 0x16, 0x24 → error=1, no port_req toggle.
- end < start (end 0x0400, start 0x0500) → error after h8, no writes. end 0xC000 → error.
- Download drops after 3 of 10 payload bytes → error=1, exactly 3 writes completed. Trailing extra bytes after a full payload → done=1, no extra writes.
- Reset asserted during DATA → all outputs return to their reset values. The next download completes normally.
